nx_axbs_arbiter: RTL and testbench
==================================

// Module: nx_axbs_arbiter
// PURPOSE
//  Shares one pipelined signed multiplier (nx_axbs) between NUM_REQ requesters.
//  - Round-robin arbitration; at most one issue per cycle.
//  - Tags each operation with its requester ID through the fixed-latency pipe.
//  - Returns products via a credit-protected response FIFO, so the non-stallable multiplier never overruns.
//  - Sits between the multiplier and its clients; the multiplier itself is instantiated externally.
// PARAMETERS
//  NUM_REQ     4   number of requesters (>=2)
//  SIZE_A      32  operand A width (signed)
//  SIZE_B      32  operand B width (signed)
//  MULT_LAT    4   cycles from mult_a/mult_b valid to mult_p valid (must match multiplier instance)
//  FIFO_DEPTH  8   response FIFO entries (>=1); full throughput needs >= MULT_LAT+2
// PORTS
//  clk        in   1                  clock
//  rst        in   1                  reset, asynchronous, active-high
//  req_valid  in   NUM_REQ            per-requester operation valid
//  req_ready  out  NUM_REQ            per-requester accept (one-hot or zero)
//  req_a      in   NUM_REQ*SIZE_A     flattened A operands, requester i at [i*SIZE_A +: SIZE_A]
//  req_b      in   NUM_REQ*SIZE_B     flattened B operands
//  mult_a     out  SIZE_A             registered operand A to multiplier
//  mult_b     out  SIZE_B             registered operand B to multiplier
//  mult_p     in   SIZE_A+SIZE_B      signed product from multiplier
//  resp_valid out  1                  response available (FIFO not empty)
//  resp_ready in   1                  consumer accepts response
//  resp_id    out  $clog2(NUM_REQ)    requester index of the response
//  resp_data  out  SIZE_A+SIZE_B      signed product
//  idle       out  1                  no op in flight and FIFO empty
// BEHAVIOUR
//  Reset (async assert, sync release) clears everything:
//   - req_ready=0, mult_a=mult_b=0, resp_valid=0, resp_id=0, resp_data=0, idle=1.
//   - RR pointer=0, credit=FIFO_DEPTH, all tag-pipe valid bits=0, FIFO empty.
//   - In-flight ops are discarded; no response ever appears for them.
//  Credit:
//   - credit counter = FIFO_DEPTH - (ops in flight + FIFO occupancy).
//   - Decrements on issue, increments on pop (resp_valid&&resp_ready).
//   - Both in the same cycle: unchanged. Never exceeds FIFO_DEPTH; never below 0.
//  Arbitration (combinational from registered credit/pointer):
//   - issue = (credit!=0) && |req_valid.
//   - Winner = first i with req_valid[i], searching from the RR pointer upward with wrap.
//   - req_ready[winner]=issue; all other bits 0.
//   - A pop in the same cycle does not bypass credit=0 (issue waits one cycle).
//   - On issue, pointer <= (winner+1) mod NUM_REQ. Otherwise pointer holds.
//   - A requester holds req_a/req_b/req_valid until its ready is seen.
//  Pipeline, for a handshake in cycle c:
//   - Cycle c+1: mult_a/mult_b hold the operands. They update only on issue and otherwise hold.
//   - A tag {valid, id} shift register of depth 1+MULT_LAT tracks the op.
//   - Cycle c+1+MULT_LAT: mult_p is sampled into the FIFO with its id.
//   - Cycle c+2+MULT_LAT: resp_valid can be high at the earliest. Minimum latency is MULT_LAT+2.
//  FIFO:
//   - Write occurs only when the tag-pipe output is valid; credit guarantees it is never full then.
//   - Response order equals issue order.
//   - resp_id/resp_data show the head entry and are stable while resp_valid && !resp_ready.
//   - Write into an empty FIFO becomes visible next cycle (no fall-through).
//   - Pointers wrap modulo FIFO_DEPTH; count width is $clog2(FIFO_DEPTH+1).
//  Arithmetic:
//   - Product is signed SIZE_A x SIZE_B -> SIZE_A+SIZE_B bits, passed through unmodified.
//  idle = (credit==FIFO_DEPTH), registered.
// TESTING (MULT_LAT=4, FIFO_DEPTH=8, NUM_REQ=4, 32x32)
//  1. req0 a=-3 b=7 at cycle 0, resp_ready=1
//     -> resp_valid in cycle 6, id=0, data=-21; idle returns to 1.
//  2. All 4 req_valid held high, resp_ready=1
//     -> grants 0,1,2,3,0,... one per cycle; responses in the same id order, no gaps.
//  3. resp_ready=0, all valid
//     -> exactly 8 accepts, then req_ready=0.
//     -> Pulse resp_ready 1 cycle: one pop, one new issue in the following cycle.
//  4. a=-2^31 b=-2^31 -> data=2^62; a=-1 b=2^31-1 -> data=-(2^31-1); a=0 b=x -> 0.
//  5. Issue 3 ops, assert rst mid-flight
//     -> no response afterwards; credit=8, pointer=0, idle=1; next op after reset has normal latency.
//  6. Pointer at 2, req_valid=4'b0011
//     -> grant req0, pointer becomes 1; next cycle grant req1.

Source files
------------

// File: rtl/nx_axbs_arbiter.sv
// Round-robin front end for one shared fixed-latency signed multiplier.
// Credits reserve a response FIFO slot at issue, so the multiplier never needs to stall.
module nx_axbs_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int SIZE_A     = 32,
    parameter int SIZE_B     = 32,
    parameter int MULT_LAT   = 4,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NUM_REQ-1:0]            req_valid,
    output logic [NUM_REQ-1:0]            req_ready,
    input  logic [NUM_REQ*SIZE_A-1:0]     req_a,
    input  logic [NUM_REQ*SIZE_B-1:0]     req_b,
    output logic [SIZE_A-1:0]             mult_a,
    output logic [SIZE_B-1:0]             mult_b,
    input  logic [SIZE_A+SIZE_B-1:0]      mult_p,
    output logic                          resp_valid,
    input  logic                          resp_ready,
    output logic [$clog2(NUM_REQ)-1:0]    resp_id,
    output logic [SIZE_A+SIZE_B-1:0]      resp_data,
    output logic                          idle
);
    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int P_W   = SIZE_A + SIZE_B;
    localparam int CNT_W = $clog2(FIFO_DEPTH + 1);
    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;

    logic [CNT_W-1:0]             r_credit;
    logic [CNT_W-1:0]             w_credit_nxt;
    logic [ID_W-1:0]              r_rr_ptr;
    logic [ID_W-1:0]              w_winner;
    logic                         w_issue;
    logic                         w_pop;
    logic                         w_push;
    logic                         r_idle;
    logic [SIZE_A-1:0]            r_mult_a;
    logic [SIZE_B-1:0]            r_mult_b;
    logic [MULT_LAT:0]            r_tag_vld;
    logic [MULT_LAT:0][ID_W-1:0]  r_tag_id;
    logic [P_W-1:0]               r_fifo_data [FIFO_DEPTH];
    logic [ID_W-1:0]              r_fifo_id   [FIFO_DEPTH];
    logic [PTR_W-1:0]             r_wr_ptr;
    logic [PTR_W-1:0]             r_rd_ptr;
    logic [CNT_W-1:0]             r_count;

    // First valid requester at or after the pointer, wrapping.
    always_comb begin : p_arb
        int  idx;
        logic found;
        idx      = 0;
        found    = 1'b0;
        w_winner = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            idx = int'(r_rr_ptr) + k;
            if (idx >= NUM_REQ) idx = idx - NUM_REQ;
            if (!found && req_valid[idx]) begin
                found    = 1'b1;
                w_winner = ID_W'(idx);
            end
        end
    end

    assign w_issue    = (r_credit != '0) && (|req_valid);
    assign resp_valid = (r_count != '0);
    assign w_pop      = resp_valid && resp_ready;
    assign w_push     = r_tag_vld[MULT_LAT];

    always_comb begin
        req_ready = '0;
        if (w_issue) req_ready[w_winner] = 1'b1;
    end

    always_comb begin
        w_credit_nxt = r_credit;
        if (w_issue && !w_pop)      w_credit_nxt = r_credit - CNT_W'(1);
        else if (!w_issue && w_pop) w_credit_nxt = r_credit + CNT_W'(1);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_credit  <= CNT_W'(FIFO_DEPTH);
            r_idle    <= 1'b1;
            r_rr_ptr  <= '0;
            r_mult_a  <= '0;
            r_mult_b  <= '0;
            r_tag_vld <= '0;
            r_tag_id  <= '0;
        end else begin
            r_credit  <= w_credit_nxt;
            r_idle    <= (w_credit_nxt == CNT_W'(FIFO_DEPTH));
            r_tag_vld <= {r_tag_vld[MULT_LAT-1:0], w_issue};
            r_tag_id  <= {r_tag_id[MULT_LAT-1:0], w_winner};
            if (w_issue) begin
                r_rr_ptr <= (w_winner == ID_W'(NUM_REQ - 1)) ? '0 : w_winner + ID_W'(1);
                r_mult_a <= req_a[w_winner*SIZE_A +: SIZE_A];
                r_mult_b <= req_b[w_winner*SIZE_B +: SIZE_B];
            end
        end
    end

    // Storage needs no reset: the count gates everything read from it.
    always_ff @(posedge clk) begin
        if (w_push) begin
            r_fifo_data[r_wr_ptr] <= mult_p;
            r_fifo_id[r_wr_ptr]   <= r_tag_id[MULT_LAT];
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push)
                r_wr_ptr <= (r_wr_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_wr_ptr + PTR_W'(1);
            if (w_pop)
                r_rd_ptr <= (r_rd_ptr == PTR_W'(FIFO_DEPTH - 1)) ? '0 : r_rd_ptr + PTR_W'(1);
            if (w_push && !w_pop)      r_count <= r_count + CNT_W'(1);
            else if (!w_push && w_pop) r_count <= r_count - CNT_W'(1);
        end
    end

    assign mult_a    = r_mult_a;
    assign mult_b    = r_mult_b;
    assign idle      = r_idle;
    assign resp_id   = resp_valid ? r_fifo_id[r_rd_ptr]   : '0;
    assign resp_data = resp_valid ? r_fifo_data[r_rd_ptr] : '0;

endmodule

// File: tb/tb_nx_axbs_arbiter.sv
// Scoreboard bench for nx_axbs_arbiter with a 4-stage behavioural multiplier.
module tb_nx_axbs_arbiter;
    logic         clk = 1'b0;
    logic         rst;
    logic [3:0]   req_valid;
    logic [3:0]   req_ready;
    logic [127:0] req_a;
    logic [127:0] req_b;
    logic [31:0]  mult_a;
    logic [31:0]  mult_b;
    logic [63:0]  mult_p;
    logic         resp_valid;
    logic         resp_ready;
    logic [1:0]   resp_id;
    logic [63:0]  resp_data;
    logic         idle;

    logic signed [31:0] op_a [4];
    logic signed [31:0] op_b [4];
    logic [63:0]        mp   [4];

    typedef struct {
        logic [1:0]  id;
        logic [63:0] data;
    } resp_t;

    resp_t exp_resp [$];
    int    exp_grant [$];
    int    checks = 0;
    int    errors = 0;

    logic [3:0] m_hs;
    logic [3:0] m_exp_hs;
    int         m_g;
    resp_t      m_r;

    nx_axbs_arbiter #(.NUM_REQ(4), .SIZE_A(32), .SIZE_B(32), .MULT_LAT(4), .FIFO_DEPTH(8)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_a(req_a), .req_b(req_b),
        .mult_a(mult_a), .mult_b(mult_b), .mult_p(mult_p),
        .resp_valid(resp_valid), .resp_ready(resp_ready),
        .resp_id(resp_id), .resp_data(resp_data),
        .idle(idle)
    );

    always #5 clk = ~clk;

    always_comb begin
        req_a = '0;
        req_b = '0;
        for (int i = 0; i < 4; i++) begin
            req_a[i*32 +: 32] = op_a[i];
            req_b[i*32 +: 32] = op_b[i];
        end
    end

    // External multiplier: product valid 4 cycles after operands.
    always_ff @(posedge clk) begin
        mp[0] <= {{32{mult_a[31]}}, mult_a} * {{32{mult_b[31]}}, mult_b};
        mp[1] <= mp[0];
        mp[2] <= mp[1];
        mp[3] <= mp[2];
    end
    assign mult_p = mp[3];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push(input int id, input logic [63:0] d);
        resp_t r;
        r.id   = 2'(id);
        r.data = d;
        exp_grant.push_back(id);
        exp_resp.push_back(r);
    endtask

    task automatic set_ops();
        op_a[0] = -5; op_b[0] = 3;
        op_a[1] = 6;  op_b[1] = -4;
        op_a[2] = -7; op_b[2] = 100;
        op_a[3] = 8;  op_b[3] = 32'sh7fff_ffff;
    endtask

    task automatic do_reset();
        rst       = 1'b1;
        req_valid = '0;
        resp_ready = 1'b0;
        tick();
        tick();
        rst = 1'b0;
        tick();
    endtask

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        do begin
            tick();
            @(negedge clk);
            n++;
        end while (!idle && n < 100);
        chk(nm, idle, 1);
    endtask

    // Monitor: compare every handshake and every response pop against the queues.
    initial begin
        forever begin
            @(negedge clk);
            if (!rst) begin
                m_hs = req_valid & req_ready;
                if (m_hs != '0) begin
                    if (exp_grant.size() == 0) begin
                        chk("grant_unexpected", m_hs, 0);
                    end else begin
                        m_g = exp_grant.pop_front();
                        m_exp_hs = '0;
                        m_exp_hs[m_g] = 1'b1;
                        chk("grant", m_hs, m_exp_hs);
                    end
                end
                if (req_ready != '0) chk("ready_onehot", $countones(req_ready), 1);
                if (resp_valid && resp_ready) begin
                    if (exp_resp.size() == 0) begin
                        chk("resp_unexpected", {resp_id, resp_data}, 0);
                    end else begin
                        m_r = exp_resp.pop_front();
                        chk("resp_id", resp_id, m_r.id);
                        chk("resp_data", resp_data, m_r.data);
                    end
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, errors %0d", errors);
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1;
        req_valid = '0;
        resp_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            op_a[i] = '0;
            op_b[i] = '0;
        end
        @(negedge clk);
        chk("rst_req_ready", req_ready, 0);
        chk("rst_mult_a", mult_a, 0);
        chk("rst_mult_b", mult_b, 0);
        chk("rst_resp_valid", resp_valid, 0);
        chk("rst_resp_id", resp_id, 0);
        chk("rst_resp_data", resp_data, 0);
        chk("rst_idle", idle, 1);
        tick();
        rst = 1'b0;
        tick();

        // 1: single op, minimum latency 6.
        resp_ready = 1'b1;
        op_a[0] = -3;
        op_b[0] = 7;
        req_valid = 4'b0001;
        push(0, -21);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            if (k == 1) req_valid = '0;
            @(negedge clk);
            chk("t1_latency", resp_valid, (k == 6));
            if (k == 3) chk("t1_busy", idle, 0);
        end
        wait_idle("t1_idle");

        // 2: all requesters, back-to-back grants and gapless responses.
        do_reset();
        set_ops();
        resp_ready = 1'b1;
        for (int k = 0; k < 12; k++) begin
            case (k % 4)
                0: push(0, -15);
                1: push(1, -24);
                2: push(2, -700);
                default: push(3, 64'd17179869176);
            endcase
        end
        for (int k = 0; k < 20; k++) begin
            if (k > 0) tick();
            req_valid = (k < 12) ? 4'hF : 4'h0;
            @(negedge clk);
            chk("t2_stream", resp_valid, (k >= 6 && k < 18));
        end
        wait_idle("t2_idle");

        // 3: credit exhaustion, single pop frees a single issue one cycle later.
        do_reset();
        set_ops();
        for (int k = 0; k < 9; k++) begin
            case (k % 4)
                0: push(0, -15);
                1: push(1, -24);
                2: push(2, -700);
                default: push(3, 64'd17179869176);
            endcase
        end
        for (int k = 0; k <= 20; k++) begin
            if (k > 0) tick();
            req_valid = 4'hF;
            resp_ready = (k == 18);
            @(negedge clk);
            if (k >= 8 && k <= 18) chk("t3_full", req_ready, 0);
            if (k == 19) chk("t3_refill", req_ready, 4'b0001);
            if (k == 20) chk("t3_full_again", req_ready, 0);
        end
        tick();
        req_valid = '0;
        resp_ready = 1'b1;
        wait_idle("t3_idle");

        // 4: arithmetic corners.
        do_reset();
        resp_ready = 1'b1;
        op_a[0] = 32'sh8000_0000;
        op_b[0] = 32'sh8000_0000;
        req_valid = 4'b0001;
        push(0, 64'h4000_0000_0000_0000);
        tick();
        op_a[0] = -1;
        op_b[0] = 32'sh7fff_ffff;
        push(0, -64'sd2147483647);
        tick();
        op_a[3] = 0;
        op_b[3] = 32'h1234_5678;
        req_valid = 4'b1000;
        push(3, 0);
        tick();
        req_valid = '0;
        wait_idle("t4_idle");

        // 5: reset mid-flight drops in-flight ops.
        do_reset();
        set_ops();
        resp_ready = 1'b1;
        req_valid = 4'b0111;
        exp_grant.push_back(0);
        exp_grant.push_back(1);
        exp_grant.push_back(2);
        tick();
        tick();
        tick();
        rst = 1'b1;
        req_valid = '0;
        tick();
        tick();
        rst = 1'b0;
        for (int k = 0; k < 10; k++) begin
            tick();
            @(negedge clk);
            chk("t5_quiet", resp_valid, 0);
        end
        chk("t5_idle", idle, 1);
        tick();
        req_valid = 4'hF;
        push(0, -15);
        for (int k = 0; k <= 6; k++) begin
            if (k > 0) tick();
            if (k == 1) req_valid = '0;
            @(negedge clk);
            chk("t5_latency", resp_valid, (k == 6));
        end
        wait_idle("t5_idle_end");

        // 6: pointer wrap search.
        do_reset();
        set_ops();
        resp_ready = 1'b1;
        req_valid = 4'b0010;
        push(1, -24);
        tick();
        req_valid = 4'b0011;
        push(0, -15);
        @(negedge clk);
        chk("t6_wrap", req_ready, 4'b0001);
        tick();
        push(1, -24);
        @(negedge clk);
        chk("t6_next", req_ready, 4'b0010);
        tick();
        req_valid = '0;
        wait_idle("t6_idle");

        chk("sb_grant_left", exp_grant.size(), 0);
        chk("sb_resp_left", exp_resp.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
